// File: rtl/multiword_add_seq_if.sv
// Handshake and data bundle for the multi-word adder sequencer.
// The requester drives the master side; the sequencer implements the slave side.
interface multiword_add_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         carry_out;

  modport master (
    output start, a_in, b_in, carry_in,
    input  busy, done, sum_out, carry_out
  );

  modport slave (
    input  start, a_in, b_in, carry_in,
    output busy, done, sum_out, carry_out
  );
endinterface

// File: rtl/multiword_add_seq.sv
// Multi-precision adder: one N-bit ripple slice per clock, least-significant word first,
// with the slice carry registered between cycles so no W-bit carry chain exists.

module ripple_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[N];
endmodule

module multiword_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  multiword_add_seq_if.slave bus
);
  localparam int W     = N * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     work_sum;
  logic [W-1:0]     work_next;
  logic [W-1:0]     sum_reg;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic             carry_out_reg;
  logic             done_reg;
  logic [N-1:0]     slice_a;
  logic [N-1:0]     slice_b;
  logic [N-1:0]     slice_sum;
  logic             slice_co;
  logic             accept;
  logic             last;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == RUN) && (idx == LAST_IDX);

  assign slice_a = a_reg[idx*N +: N];
  assign slice_b = b_reg[idx*N +: N];

  ripple_adder #(.N(N)) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_reg),
    .s  (slice_sum),
    .co (slice_co)
  );

  // Working sum with the current slice merged in; also the final result on the last edge.
  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    work_next = work_sum;
    work_next[idx*N +: N] = slice_sum;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: operand registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= bus.a_in;
      b_reg <= bus.b_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      carry_reg     <= 1'b0;
      work_sum      <= '0;
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        idx       <= '0;
        carry_reg <= bus.carry_in;
      end else if (state == RUN) begin
        work_sum  <= work_next;
        carry_reg <= slice_co;
        idx       <= idx + 1'b1;
        if (last) begin
          sum_reg       <= work_next;
          carry_out_reg <= slice_co;
          done_reg      <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = done_reg;
  assign bus.sum_out   = sum_reg;
  assign bus.carry_out = carry_out_reg;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed and random operations checked against
// plain (W+1)-bit arithmetic, including abort-by-reset and back-to-back starts.
module tb_multiword_add_seq;
  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;
  localparam int NB    = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multiword_add_seq_if #(.W(W)) bus ();

  multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_sum;
  logic         exp_co;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci);
    return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
  endfunction

  // One complete operation; with disturb set, start is re-pulsed and operands scrambled during RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input bit disturb);
    logic [W:0] r;
    r = model(a, b, ci);
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b; bus.carry_in = ci;
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk);
      bus.start = disturb && (k % 2 == 0) && (k < WORDS - 1);
      if (disturb) begin
        bus.a_in     = W'($urandom);
        bus.b_in     = W'($urandom);
        bus.carry_in = ~ci;
      end
      check("busy_run", bus.busy, 1);
      check("done_low_run", bus.done, 0);
      check("result_hold", {bus.carry_out, bus.sum_out}, {exp_co, exp_sum});
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_pulse", bus.done, 1);
    check("busy_done", bus.busy, 0);
    check("result", {bus.carry_out, bus.sum_out}, r);
    {exp_co, exp_sum} = r;
    @(negedge clk);
    check("done_single", bus.done, 0);
    check("busy_after", bus.busy, 0);
  endtask

  logic [W-1:0] bb_a [NB];
  logic [W-1:0] bb_b [NB];
  logic         bb_c [NB];

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.carry_in = 1'b0;
    exp_sum = '0; exp_co = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", {bus.carry_out, bus.sum_out}, 0);
    reset = 1'b0;

    run_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(16'hA5C3, 16'h5A3C, 1'b0, 1'b1);

    // Abort with reset during the second RUN cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 16'h7777; bus.b_in = 16'h8888; bus.carry_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", {bus.carry_out, bus.sum_out}, 0);
    exp_sum = '0; exp_co = 1'b0;
    for (int k = 0; k < WORDS + 2; k++) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'(i % 2));

    // Back-to-back: start held high, new operands presented for each accept.
    for (int i = 0; i < NB; i++) begin
      bb_a[i] = W'($urandom); bb_b[i] = W'($urandom); bb_c[i] = 1'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = bb_a[0]; bus.b_in = bb_b[0]; bus.carry_in = bb_c[0];
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check("b2b_accept", bus.busy, 1);
      if (i < NB - 1) begin
        bus.a_in = bb_a[i+1]; bus.b_in = bb_b[i+1]; bus.carry_in = bb_c[i+1];
      end else begin
        bus.start = 1'b0;
      end
      for (int k = 1; k < WORDS; k++) begin
        @(negedge clk);
        check("b2b_busy", bus.busy, 1);
        check("b2b_done_low", bus.done, 0);
        check("b2b_hold", {bus.carry_out, bus.sum_out}, {exp_co, exp_sum});
      end
      @(negedge clk);
      check("b2b_done", bus.done, 1);
      check("b2b_busy_done", bus.busy, 0);
      check("b2b_result", {bus.carry_out, bus.sum_out}, model(bb_a[i], bb_b[i], bb_c[i]));
      {exp_co, exp_sum} = model(bb_a[i], bb_b[i], bb_c[i]);
    end
    @(negedge clk);
    check("b2b_end_done", bus.done, 0);
    check("b2b_end_busy", bus.busy, 0);
    check("b2b_end_hold", {bus.carry_out, bus.sum_out}, {exp_co, exp_sum});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
